// File: rtl/rv_mdu_pkg.sv
// Shared types for the RV32M multiply/divide unit: funct3-encoded op codes,
// control-FSM states and operand signedness decode.
package rv_mdu_pkg;

  typedef enum logic [2:0] {
    MDU_MUL    = 3'd0,
    MDU_MULH   = 3'd1,
    MDU_MULHSU = 3'd2,
    MDU_MULHU  = 3'd3,
    MDU_DIV    = 3'd4,
    MDU_DIVU   = 3'd5,
    MDU_REM    = 3'd6,
    MDU_REMU   = 3'd7
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mdu_state_e;

  function automatic logic is_signed_a(mdu_op_e op);
    return (op == MDU_MULH) || (op == MDU_MULHSU) || (op == MDU_DIV) || (op == MDU_REM);
  endfunction

  function automatic logic is_signed_b(mdu_op_e op);
    return (op == MDU_MULH) || (op == MDU_DIV) || (op == MDU_REM);
  endfunction

  function automatic logic is_div(mdu_op_e op);
    return op[2];
  endfunction

endpackage

// File: rtl/rv_mdu.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring
// divide on magnitudes, sharing one accumulator. Optional RV_MDU_EARLY_OUT_EN.
module rv_mdu
  import rv_mdu_pkg::*;
#(
  parameter int DPWIDTH = 32,
  parameter int CNTW    = $clog2(DPWIDTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [2:0]         op,
  input  logic [DPWIDTH-1:0] opa,
  input  logic [DPWIDTH-1:0] opb,
  output logic               busy,
  output logic               done,
  output logic [DPWIDTH-1:0] result
);

  localparam int W  = DPWIDTH;
  localparam int AW = 2 * W + 1;
  localparam logic [W-1:0] MINV = {1'b1, {(W-1){1'b0}}};

  mdu_state_e      state_q, state_d;
  mdu_op_e         op_q, op_d;
  logic [AW-1:0]   acc_q, acc_d;
  logic [W-1:0]    opnd_q, opnd_d;
  logic            neg_q, neg_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [W-1:0]    result_q, result_d;

  // Operand decode at capture time
  mdu_op_e      op_in;
  logic         sa, sb;
  logic [W-1:0] mag_a, mag_b;
  logic         div_zero, div_ovf;

  assign op_in    = mdu_op_e'(op);
  assign sa       = is_signed_a(op_in) & opa[W-1];
  assign sb       = is_signed_b(op_in) & opb[W-1];
  assign mag_a    = sa ? -opa : opa;
  assign mag_b    = sb ? -opb : opb;
  assign div_zero = is_div(op_in) && (opb == '0);
  assign div_ovf  = ((op_in == MDU_DIV) || (op_in == MDU_REM)) && (opa == MINV) && (opb == '1);

  // Multiply step: low half holds the unconsumed multiplier, shifted out LSB first
  logic [W:0]    mul_sum;
  logic [AW-1:0] mul_next;
  assign mul_sum  = acc_q[AW-1:W] + {1'b0, (acc_q[0] ? opnd_q : {W{1'b0}})};
  assign mul_next = {mul_sum, acc_q[W-1:0]} >> 1;

  // Divide step: low half holds dividend bits, quotient bits enter at the LSB
  logic [AW-1:0] div_sh, div_next;
  logic [W:0]    div_hi, div_diff;
  logic          div_ge;
  assign div_sh   = acc_q << 1;
  assign div_hi   = div_sh[AW-1:W];
  assign div_ge   = div_hi >= {1'b0, opnd_q};
  assign div_diff = div_hi - {1'b0, opnd_q};
  assign div_next = div_ge ? {div_diff, div_sh[W-1:1], 1'b1} : div_sh;

  logic [AW-1:0] step_next, fin_acc;
  logic          early;
  assign step_next = is_div(op_q) ? div_next : mul_next;

`ifdef RV_MDU_EARLY_OUT_EN
  // Multiplier bits still waiting above the one consumed this cycle
  logic [W-1:0] rest_mask;
  assign rest_mask = ((W'(1) << cnt_q) - W'(1)) & ~W'(1);
  assign early     = !is_div(op_q) && ((acc_q[W-1:0] & rest_mask) == '0);
  assign fin_acc   = early ? (step_next >> (cnt_q - CNTW'(1))) : step_next;
`else
  assign early     = 1'b0;
  assign fin_acc   = step_next;
`endif

  // Sign correction of the finished accumulator
  logic [2*W-1:0] prod, prod_c;
  logic [W-1:0]   quo, rem, fin_res;
  assign prod   = fin_acc[2*W-1:0];
  assign prod_c = neg_q ? -prod : prod;
  assign quo    = fin_acc[W-1:0];
  assign rem    = fin_acc[2*W-1:W];

  always_comb begin
    fin_res = prod_c[2*W-1:W];
    case (op_q)
      MDU_MUL:             fin_res = prod_c[W-1:0];
      MDU_DIV, MDU_DIVU:   fin_res = neg_q ? -quo : quo;
      MDU_REM, MDU_REMU:   fin_res = neg_q ? -rem : rem;
      default:             fin_res = prod_c[2*W-1:W];
    endcase
  end

  logic unused_ok;
  assign unused_ok = fin_acc[AW-1];

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    neg_d    = neg_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    case (state_q)
      CALC: begin
        acc_d = step_next;
        cnt_d = cnt_q - CNTW'(1);
        if ((cnt_q == CNTW'(1)) || early) begin
          result_d = fin_res;
          cnt_d    = '0;
          state_d  = DONE;
        end
      end
      default: begin
        if (state_q == DONE) state_d = IDLE;
        if (start) begin
          if (div_zero) begin
            result_d = ((op_in == MDU_DIV) || (op_in == MDU_DIVU)) ? '1 : opa;
            state_d  = DONE;
          end else if (div_ovf) begin
            result_d = (op_in == MDU_DIV) ? opa : '0;
            state_d  = DONE;
          end else begin
            op_d    = op_in;
            neg_d   = ((op_in == MDU_REM) || (op_in == MDU_REMU)) ? sa : (sa ^ sb);
            acc_d   = {{(W+1){1'b0}}, (is_div(op_in) ? mag_a : mag_b)};
            opnd_d  = is_div(op_in) ? mag_b : mag_a;
            cnt_d   = CNTW'(W);
            state_d = CALC;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      op_q     <= MDU_MUL;
      acc_q    <= '0;
      opnd_q   <= '0;
      neg_q    <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      neg_q    <= neg_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  assign busy   = (state_q == CALC);
  assign done   = (state_q == DONE);
  assign result = result_q;

endmodule

// File: tb/tb_rv_mdu.sv
// Scoreboard bench for rv_mdu: directed ops push expected result and latency,
// an edge-driven monitor pops and checks on every done pulse.
module tb_rv_mdu;
  import rv_mdu_pkg::*;

  localparam int W = 32;
`ifdef RV_MDU_EARLY_OUT_EN
  localparam bit EO = 1'b1;
`else
  localparam bit EO = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [2:0]   op = 3'd0;
  logic [W-1:0] opa = '0, opb = '0;
  logic         busy, done;
  logic [W-1:0] result;

  rv_mdu #(.DPWIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .opa(opa), .opb(opb),
    .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0, ecount = 0;
  logic [W-1:0] exp_q[$];
  int           lat_q[$];
  int           e0_q[$];
  string        name_q[$];

  task automatic chk(string nm, logic [W-1:0] act, logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%h expected 0x%h", nm, act, exp);
    end
  endtask

  // Monitor: latency counts the start edge as edge 1
  initial begin
    logic [W-1:0] e;
    int l, s;
    string nm;
    forever begin
      @(posedge clk);
      ecount++;
      #1;
      if (done === 1'b1) begin
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_done: result 0x%h with no pending op", result);
        end else begin
          e = exp_q.pop_front(); l = lat_q.pop_front();
          s = e0_q.pop_front();  nm = name_q.pop_front();
          chk({nm, "_result"}, result, e);
          tests++;
          if (ecount - s + 1 != l) begin
            fails++;
            $display("FAIL %s_latency: got %0d edges expected %0d", nm, ecount - s + 1, l);
          end
        end
      end
    end
  end

  task automatic issue(mdu_op_e o, logic [W-1:0] a, logic [W-1:0] b,
                       logic [W-1:0] e, int lat, string nm);
    @(negedge clk);
    op = o; opa = a; opb = b; start = 1'b1;
    exp_q.push_back(e); lat_q.push_back(lat);
    e0_q.push_back(ecount + 1); name_q.push_back(nm);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain(int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      tests++; fails++;
      $display("FAIL timeout: %0d ops pending, expected 0", exp_q.size());
      exp_q.delete(); lat_q.delete(); e0_q.delete(); name_q.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int bcnt;
    repeat (3) @(negedge clk);
    chk("rst_busy",   W'(busy), '0);
    chk("rst_done",   W'(done), '0);
    chk("rst_result", result,   '0);
    rst = 1'b0;

    issue(MDU_MUL, 32'd7, 32'd6, 32'd42, EO ? 4 : 33, "mul_7x6");
    bcnt = 0;
    for (int i = 0; i < 100; i++) begin
      if (done) break;
      if (busy) bcnt++;
      @(negedge clk);
    end
    chk("mul_busy_cycles", W'(bcnt), EO ? 32'd3 : 32'd32);
    drain(50);

    issue(MDU_MUL,    32'hFFFFFFFD, 32'd5,        32'hFFFFFFF1, EO ? 4 : 33, "mul_neg");      drain(50);
    issue(MDU_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 33, "mulh_min");              drain(50);
    issue(MDU_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33, "mulhu_max");             drain(50);
    issue(MDU_MULHSU, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, EO ? 3 : 33, "mulhsu");       drain(50);
    issue(MDU_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33, "div_m7_2");              drain(50);
    issue(MDU_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33, "rem_m7_2");              drain(50);
    issue(MDU_DIV,    32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 33, "div_7_m2");              drain(50);
    issue(MDU_REM,    32'd7,        32'hFFFFFFFE, 32'd1,        33, "rem_7_m2");              drain(50);
    issue(MDU_REMU,   32'd100,      32'd7,        32'd2,        33, "remu_100_7");            drain(50);
    issue(MDU_REM,    32'h80000000, 32'hFFFFFFFF, 32'd0,        1,  "rem_ovf");               drain(50);
    issue(MDU_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1,  "div_ovf");               drain(50);
    issue(MDU_REMU,   32'd9,        32'd0,        32'd9,        1,  "remu_by0");              drain(50);
    issue(MDU_DIVU,   32'd5,        32'd0,        32'hFFFFFFFF, 1,  "divu_by0");              drain(50);

    // Abandon an operation with reset mid-CALC; no done may follow
    @(negedge clk);
    op = MDU_DIVU; opa = 32'd100; opb = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_busy",   W'(busy), '0);
    chk("midrst_done",   W'(done), '0);
    chk("midrst_result", result,   '0);
    @(negedge clk);
    rst = 1'b0;

    // start pulsed during CALC must not disturb the running divide
    issue(MDU_DIVU, 32'd100, 32'd7, 32'd14, 33, "divu_100_7");
    repeat (4) @(negedge clk);
    op = MDU_MUL; opa = 32'd50; opb = 32'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain(50);

    // Back-to-back: start held during DONE
    issue(MDU_MUL, 32'd3, 32'd1, 32'd3, EO ? 2 : 33, "mul_3x1");
    for (int i = 0; i < 40 && !done; i++) @(negedge clk);
    op = MDU_DIVU; opa = 32'd100; opb = 32'd7; start = 1'b1;
    exp_q.push_back(32'd14); lat_q.push_back(33);
    e0_q.push_back(ecount + 1); name_q.push_back("b2b_divu");
    @(negedge clk);
    start = 1'b0;
    chk("b2b_busy", W'(busy), 32'd1);
    drain(50);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rv_mdu.md
Name: rv_mdu

Overview:
Parametrised iterative multiply/divide execute unit implementing the RV32M operations MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU. It sits beside the datapath's single-cycle ALU. The multicycle control FSM starts an operation, stalls while busy, and writes back result on done. Both operand width and multiply latency are configurable.

Parameters:
DPWIDTH, 32, operand/result width in bits; must be even and >= 8.
CNTW, $clog2(DPWIDTH)+1, iteration counter width (derived; do not override).

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
start  input  1  request; sampled only when state is IDLE or DONE
op  input  3  operation code, captured with start (see package)
opa  input  DPWIDTH  rs1 operand, captured with start
opb  input  DPWIDTH  rs2 operand, captured with start
busy  output  1  high while iterating; controller must hold stall
done  output  1  one-cycle pulse: result valid
result  output  DPWIDTH  final result; held stable until next accepted start

Behaviour:
- Reset: synchronous active-high reset on a rising clk edge with rst=1. Forces state=IDLE, busy=0, done=0, result=0, counter=0. Reset mid-operation abandons the operation with no done pulse. rst has priority over start.
- States: IDLE, CALC, DONE.
- IDLE/DONE with start=1 -> capture op/opa/opb:
  - compute operand magnitudes (signed ops: two's-complement abs; MULHSU: opa signed, opb unsigned);
  - record result sign: product = sa^sb; quotient = sa^sb; remainder = sign of opa;
  - clear partial accumulator; counter=DPWIDTH; go CALC.
- start in CALC is ignored; operands are not recaptured.
- Fast paths: go directly to DONE on the next edge, never entering CALC:
  - Divide by zero (opb==0): DIV/DIVU quotient = all ones; REM/REMU = opa.
  - Signed overflow (DIV/REM, opa = most-negative, opb = all ones): DIV = opa; REM = 0.
- Multiply: radix-2 shift-add, one multiplier bit per cycle into a 2*DPWIDTH accumulator.
  - MUL returns the low half of the product.
  - MULH, MULHSU and MULHU return the high half of the sign-corrected 2*DPWIDTH product.
- Divide: restoring, one quotient bit per cycle, DPWIDTH cycles.
  - Remainder is sign-corrected to the dividend's sign; quotient to sa^sb.
- CALC: counter decrements each cycle. At counter==1 the next edge applies the sign correction, loads result, and moves to DONE.
- DONE lasts exactly one cycle with done=1. Next state is CALC if start=1 (back-to-back), else IDLE.
- busy=1 exactly while state==CALC.
- Latency: the edge sampling start is E0.
  - Normal op: done high after edge E0+DPWIDTH+1.
  - Fast path: done high after edge E0+1.
- result updates only on the transition into DONE; it is unchanged in IDLE and CALC.
- All arithmetic is modulo 2^DPWIDTH at the output. Internal accumulators are 2*DPWIDTH+1 bits to hold the borrow.

Optional Feature:
RV_MDU_EARLY_OUT_EN
- Defined: for multiply ops in CALC, if the remaining unshifted multiplier bits are all zero, finish early. The next edge shifts the accumulator by the remaining count, applies sign correction and enters DONE.
  - Minimum multiply latency is 2 edges (opb magnitude 0 or 1).
  - Divide latency is unchanged.
- Undefined: multiply always takes DPWIDTH CALC cycles; the early-out comparator is not synthesised.

Decomposition:
- Package rv_mdu_pkg holds:
  - op enum, 3 bits: MDU_MUL=0, MDU_MULH=1, MDU_MULHSU=2, MDU_MULHU=3, MDU_DIV=4, MDU_DIVU=5, MDU_REM=6, MDU_REMU=7 (matching funct3);
  - state enum: IDLE, CALC, DONE;
  - helper function is_signed_a/is_signed_b(op).
- The control FSM's stall decode imports the same package.
- Single module. The datapath (shared shift register and add/sub) is small enough that no sub-module is warranted.

Test Plan (DPWIDTH=32; early-out undefined unless stated):
- MUL opa=7, opb=6 -> done 33 edges after the start edge, result=42, busy high for 32 cycles.
- MULH opa=0x80000000, opb=0x80000000 -> result=0x40000000. MULHU opa=0xFFFFFFFF, opb=0xFFFFFFFF -> result=0xFFFFFFFE.
- DIV opa=-7 (0xFFFFFFF9), opb=2 -> result=0xFFFFFFFD (-3). REM with the same operands -> 0xFFFFFFFF (-1).
- DIVU opa=5, opb=0 -> done 1 edge after start, result=0xFFFFFFFF. REM opa=0x80000000, opb=0xFFFFFFFF -> result=0 after 1 edge.
- Assert rst mid-CALC of DIVU 100/7 -> next edge: busy=0, done=0, result=0. A following DIVU 100/7 -> result=14 with full latency. start pulsed during CALC has no effect.
- With RV_MDU_EARLY_OUT_EN: MUL opa=3, opb=1 -> done 2 edges after start, result=3. Back-to-back start held high during DONE -> second op accepted, busy rises the following cycle.
